// File: rtl/bp_commit_trace_matcher_pkg.sv
// rtl/bp_commit_trace_matcher_pkg.sv - shared constants and helpers for the commit trace matcher
package bp_commit_trace_matcher_pkg;

    localparam int unsigned drop_cnt_width_lp = 16;

    // Counter increment that parks at all-ones instead of wrapping
    function automatic logic [drop_cnt_width_lp-1:0] sat_inc16(input logic [drop_cnt_width_lp-1:0] v);
        return (v == {drop_cnt_width_lp{1'b1}}) ? v : v + {{(drop_cnt_width_lp-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bp_commit_trace_matcher_if.sv
// rtl/bp_commit_trace_matcher_if.sv - trace record stream between matcher and trace sink
interface bp_commit_trace_matcher_if #(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int itag_width_p     = 30
);
    logic                        trace_v;
    logic                        trace_ready;
    logic [itag_width_p-1:0]     trace_itag;
    logic [vaddr_width_p-1:0]    trace_pc;
    logic [instr_width_p-1:0]    trace_instr;
    logic                        trace_rd_v;
    logic [reg_addr_width_p-1:0] trace_rd_addr;
    logic [dword_width_p-1:0]    trace_rd_data;

    modport master (
        output trace_v, trace_itag, trace_pc, trace_instr,
               trace_rd_v, trace_rd_addr, trace_rd_data,
        input  trace_ready
    );

    modport slave (
        input  trace_v, trace_itag, trace_pc, trace_instr,
               trace_rd_v, trace_rd_addr, trace_rd_data,
        output trace_ready
    );
endinterface

// File: rtl/bp_commit_trace_matcher_fifo.sv
// rtl/bp_commit_trace_matcher_fifo.sv - circular pending-commit buffer with wrap-bit full/empty
module bp_commit_trace_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp:0] ptr_one_lp = {{ptr_w_lp{1'b0}}, 1'b1};

    logic [ptr_w_lp:0]  r_wptr;
    logic [ptr_w_lp:0]  r_rptr;
    logic [width_p-1:0] r_mem [els_p];

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[ptr_w_lp] != r_rptr[ptr_w_lp])
                  && (r_wptr[ptr_w_lp-1:0] == r_rptr[ptr_w_lp-1:0]);
    assign data_o  = r_mem[r_rptr[ptr_w_lp-1:0]];

    // Pointer advance; the extra MSB distinguishes full from empty
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + ptr_one_lp;
            if (pop_i)  r_rptr <= r_rptr + ptr_one_lp;
        end
    end

    // Storage write; contents are meaningless while the pointers say empty
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr[ptr_w_lp-1:0]] <= data_i;
    end
endmodule

// File: rtl/bp_commit_trace_matcher.sv
// rtl/bp_commit_trace_matcher.sv - commit/writeback pairing and ordered trace record emission
module bp_commit_trace_matcher
    import bp_commit_trace_matcher_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int els_p            = 8,
    parameter int align_delay_p    = 3,
    parameter int itag_width_p     = 30,
    parameter int filter_zero_pc_p = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          commit_v_i,
    input  logic [vaddr_width_p-1:0]      commit_pc_i,
    input  logic [instr_width_p-1:0]      commit_instr_i,
    input  logic                          rd_expected_i,
    input  logic                          rd_w_v_i,
    input  logic [reg_addr_width_p-1:0]   rd_addr_i,
    input  logic [dword_width_p-1:0]      rd_data_i,
    bp_commit_trace_matcher_if.master     trace,
    output logic [drop_cnt_width_lp-1:0]  drop_cnt_o,
    output logic                          err_spurious_wb_o,
    output logic                          err_wb_overflow_o
);
    typedef struct packed {
        logic [itag_width_p-1:0]  itag;
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic                     rd_exp;
    } entry_s;

    localparam int entry_width_lp = $bits(entry_s);
    localparam int cnt_w_lp       = $clog2(els_p + 1);
    localparam logic [itag_width_p-1:0] itag_one_lp = {{(itag_width_p-1){1'b0}}, 1'b1};
    localparam logic [cnt_w_lp-1:0]     cnt_one_lp  = {{(cnt_w_lp-1){1'b0}}, 1'b1};

    logic                        w_rd_exp_aligned;
    logic [itag_width_p-1:0]     r_itag;
    logic [cnt_w_lp-1:0]         r_exp_cnt;
    logic                        r_wb_v;
    logic [reg_addr_width_p-1:0] r_wb_addr;
    logic [dword_width_p-1:0]    r_wb_data;
    logic [drop_cnt_width_lp-1:0] r_drop_cnt;
    logic                        r_err_spurious;
    logic                        r_err_overflow;

    logic                        r_out_v;
    logic [itag_width_p-1:0]     r_out_itag;
    logic [vaddr_width_p-1:0]    r_out_pc;
    logic [instr_width_p-1:0]    r_out_instr;
    logic                        r_out_rd_v;
    logic [reg_addr_width_p-1:0] r_out_rd_addr;
    logic [dword_width_p-1:0]    r_out_rd_data;

    entry_s                      w_push_entry;
    entry_s                      w_head;
    logic [entry_width_lp-1:0]   w_head_raw;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic                        w_head_ok;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_emit;
    logic                        w_wb_consume;
    logic                        w_wb_spurious;
    logic                        w_wb_overflow;
    logic                        w_wb_capture;

    // rd_expected_i leads its commit by align_delay_p cycles; delay it to line up
    generate
        if (align_delay_p == 0) begin : g_no_align
            assign w_rd_exp_aligned = rd_expected_i;
        end else begin : g_align
            logic [align_delay_p-1:0] r_align;

            // Shift register feeding the aligned expectation bit
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_align <= '0;
                end else begin
                    r_align[0] <= rd_expected_i;
                    for (int i = 1; i < align_delay_p; i++) r_align[i] <= r_align[i-1];
                end
            end

            assign w_rd_exp_aligned = r_align[align_delay_p-1];
        end
    endgenerate

    assign w_push_entry = '{itag: r_itag, pc: commit_pc_i, instr: commit_instr_i, rd_exp: w_rd_exp_aligned};
    assign w_head       = entry_s'(w_head_raw);

    // The head only leaves while the consumer is ready, so a stalled sink backs up into the FIFO
    assign w_head_ok = !w_fifo_empty && (!w_head.rd_exp || r_wb_v);
    assign w_pop     = w_head_ok && trace.trace_ready;
    assign w_push    = commit_v_i && (!w_fifo_full || w_pop);
    assign w_drop    = commit_v_i && !w_push;
    assign w_emit    = !((filter_zero_pc_p != 0) && (w_head.pc == '0));

    assign w_wb_consume  = w_pop && w_head.rd_exp;
    assign w_wb_spurious = rd_w_v_i && (r_exp_cnt == '0);
    assign w_wb_overflow = rd_w_v_i && !w_wb_spurious && r_wb_v && !w_wb_consume;
    assign w_wb_capture  = rd_w_v_i && !w_wb_spurious && !w_wb_overflow;

    bp_commit_trace_fifo #(
        .width_p (entry_width_lp),
        .els_p   (els_p)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (w_push),
        .data_i    (w_push_entry),
        .pop_i     (w_pop),
        .data_o    (w_head_raw),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    // Sequence tag advances on every commit, dropped or not, so gaps reveal drops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)      r_itag <= '0;
        else if (commit_v_i) r_itag <= r_itag + itag_one_lp;
    end

    // Number of queued entries still waiting on a writeback
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_exp_cnt <= '0;
        end else begin
            case ({w_push && w_push_entry.rd_exp, w_wb_consume})
                2'b10:   r_exp_cnt <= r_exp_cnt + cnt_one_lp;
                2'b01:   r_exp_cnt <= r_exp_cnt - cnt_one_lp;
                default: r_exp_cnt <= r_exp_cnt;
            endcase
        end
    end

    // Single writeback holding register, emptied when an expecting head pops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wb_v    <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_wb_capture) begin
            r_wb_v    <= 1'b1;
            r_wb_addr <= rd_addr_i;
            r_wb_data <= rd_data_i;
        end else if (w_wb_consume) begin
            r_wb_v    <= 1'b0;
        end
    end

    // Drop counter and sticky error flags
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_drop_cnt     <= '0;
            r_err_spurious <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_drop)        r_drop_cnt     <= sat_inc16(r_drop_cnt);
            if (w_wb_spurious) r_err_spurious <= 1'b1;
            if (w_wb_overflow) r_err_overflow <= 1'b1;
        end
    end

    // Output record register; filtered zero-PC records pop without becoming valid
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_out_v       <= 1'b0;
            r_out_itag    <= '0;
            r_out_pc      <= '0;
            r_out_instr   <= '0;
            r_out_rd_v    <= 1'b0;
            r_out_rd_addr <= '0;
            r_out_rd_data <= '0;
        end else if (w_pop) begin
            r_out_v <= w_emit;
            if (w_emit) begin
                r_out_itag    <= w_head.itag;
                r_out_pc      <= w_head.pc;
                r_out_instr   <= w_head.instr;
                r_out_rd_v    <= w_head.rd_exp;
                r_out_rd_addr <= w_head.rd_exp ? r_wb_addr : '0;
                r_out_rd_data <= w_head.rd_exp ? r_wb_data : '0;
            end
        end else if (trace.trace_ready) begin
            r_out_v <= 1'b0;
        end
    end

    assign trace.trace_v       = r_out_v;
    assign trace.trace_itag    = r_out_itag;
    assign trace.trace_pc      = r_out_pc;
    assign trace.trace_instr   = r_out_instr;
    assign trace.trace_rd_v    = r_out_rd_v;
    assign trace.trace_rd_addr = r_out_rd_addr;
    assign trace.trace_rd_data = r_out_rd_data;

    assign drop_cnt_o        = r_drop_cnt;
    assign err_spurious_wb_o = r_err_spurious;
    assign err_wb_overflow_o = r_err_overflow;
endmodule

// File: tb/tb_bp_commit_trace_matcher.sv
// tb/tb_bp_commit_trace_matcher.sv - scoreboard bench for the commit trace matcher
module tb_bp_commit_trace_matcher;
    localparam int VA = 39;
    localparam int IW = 32;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int EL = 8;
    localparam int AD = 3;
    localparam int TW = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          commit_v_i;
    logic [VA-1:0] commit_pc_i;
    logic [IW-1:0] commit_instr_i;
    logic          rd_expected_i;
    logic          rd_w_v_i;
    logic [RW-1:0] rd_addr_i;
    logic [DW-1:0] rd_data_i;
    logic [15:0]   drop_cnt_o;
    logic          err_spurious_wb_o;
    logic          err_wb_overflow_o;

    bp_commit_trace_matcher_if #(
        .vaddr_width_p(VA), .instr_width_p(IW), .dword_width_p(DW),
        .reg_addr_width_p(RW), .itag_width_p(TW)
    ) trace_if ();

    bp_commit_trace_matcher #(
        .vaddr_width_p(VA), .instr_width_p(IW), .dword_width_p(DW),
        .reg_addr_width_p(RW), .els_p(EL), .align_delay_p(AD),
        .itag_width_p(TW), .filter_zero_pc_p(1)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .commit_v_i        (commit_v_i),
        .commit_pc_i       (commit_pc_i),
        .commit_instr_i    (commit_instr_i),
        .rd_expected_i     (rd_expected_i),
        .rd_w_v_i          (rd_w_v_i),
        .rd_addr_i         (rd_addr_i),
        .rd_data_i         (rd_data_i),
        .trace             (trace_if),
        .drop_cnt_o        (drop_cnt_o),
        .err_spurious_wb_o (err_spurious_wb_o),
        .err_wb_overflow_o (err_wb_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [TW-1:0] itag;
        logic [VA-1:0] pc;
        logic [IW-1:0] instr;
        logic          rd_v;
        logic [RW-1:0] rd_addr;
        logic [DW-1:0] rd_data;
    } rec_t;

    rec_t          sbq[$];
    rec_t          mon_e;
    logic [VA-1:0] b_pc[$];
    logic [IW-1:0] b_instr[$];
    logic          b_exp[$];
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Monitor: every accepted record must match the head of the expected queue
    always @(negedge clk_i) begin
        if (reset_n_i && trace_if.trace_v && trace_if.trace_ready) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_record: got itag %0h pc %0h required no record",
                         trace_if.trace_itag, trace_if.trace_pc);
            end else begin
                mon_e = sbq.pop_front();
                check("rec_itag",    64'(trace_if.trace_itag),    64'(mon_e.itag));
                check("rec_pc",      64'(trace_if.trace_pc),      64'(mon_e.pc));
                check("rec_instr",   64'(trace_if.trace_instr),   64'(mon_e.instr));
                check("rec_rd_v",    64'(trace_if.trace_rd_v),    64'(mon_e.rd_v));
                check("rec_rd_addr", 64'(trace_if.trace_rd_addr), 64'(mon_e.rd_addr));
                check("rec_rd_data", trace_if.trace_rd_data,      mon_e.rd_data);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input int itag, input logic [VA-1:0] pc, input logic [IW-1:0] instr,
                            input logic rd_v, input logic [RW-1:0] a, input logic [DW-1:0] d);
        rec_t r;
        r.itag = TW'(itag); r.pc = pc; r.instr = instr;
        r.rd_v = rd_v; r.rd_addr = a; r.rd_data = d;
        sbq.push_back(r);
    endtask

    task automatic add_commit(input logic [VA-1:0] pc, input logic [IW-1:0] instr, input logic e);
        b_pc.push_back(pc); b_instr.push_back(instr); b_exp.push_back(e);
    endtask

    // Drives each rd_expected bit AD cycles ahead of its commit; returns one tick after the last commit edge
    task automatic run_burst();
        int n = b_pc.size();
        for (int c = 0; c < n + AD; c++) begin
            rd_expected_i = (c < n) ? b_exp[c] : 1'b0;
            if (c >= AD) begin
                commit_v_i     = 1'b1;
                commit_pc_i    = b_pc[c-AD];
                commit_instr_i = b_instr[c-AD];
            end else begin
                commit_v_i = 1'b0;
            end
            step();
        end
        commit_v_i = 1'b0; rd_expected_i = 1'b0;
        b_pc.delete(); b_instr.delete(); b_exp.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && sbq.size() != 0; i++) step();
        check(name, 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        commit_v_i = 1'b0; commit_pc_i = '0; commit_instr_i = '0; rd_expected_i = 1'b0;
        rd_w_v_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
        sbq.delete();
        repeat (3) step();
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic writeback(input logic [RW-1:0] a, input logic [DW-1:0] d);
        rd_w_v_i = 1'b1; rd_addr_i = a; rd_data_i = d;
        step();
        rd_w_v_i = 1'b0;
    endtask

    initial begin
        logic seen;
        trace_if.trace_ready = 1'b1;
        do_reset();

        // Reset state
        check("reset_trace_v",  64'(trace_if.trace_v), 64'd0);
        check("reset_itag",     64'(trace_if.trace_itag), 64'd0);
        check("reset_pc",       64'(trace_if.trace_pc), 64'd0);
        check("reset_rd_data",  trace_if.trace_rd_data, 64'd0);
        check("reset_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("reset_err_sp",   64'(err_spurious_wb_o), 64'd0);
        check("reset_err_ov",   64'(err_wb_overflow_o), 64'd0);

        // Single non-writeback commit: record two cycles after commit
        repeat (3) step();
        add_commit(39'h80000000, 32'h00000013, 1'b0);
        push_exp(0, 39'h80000000, 32'h00000013, 1'b0, '0, '0);
        run_burst();
        check("lat_commit_n1", 64'(trace_if.trace_v), 64'd0);
        step();
        check("lat_commit_n2", 64'(trace_if.trace_v), 64'd1);
        wait_drain("drain_single");

        // Long-latency: no record until the writeback, then record at writeback+2
        add_commit(39'h80000004, 32'h00a00293, 1'b1);
        push_exp(1, 39'h80000004, 32'h00a00293, 1'b1, 5'd5, 64'hDEADBEEF);
        run_burst();
        seen = 1'b0;
        repeat (19) begin
            if (trace_if.trace_v) seen = 1'b1;
            step();
        end
        check("no_early_record", 64'(seen), 64'd0);
        writeback(5'd5, 64'hDEADBEEF);
        check("lat_wb_m1", 64'(trace_if.trace_v), 64'd0);
        step();
        check("lat_wb_m2", 64'(trace_if.trace_v), 64'd1);
        wait_drain("drain_long");
        check("long_no_err_sp", 64'(err_spurious_wb_o), 64'd0);

        // Full FIFO under back-pressure: 10 commits, 8 kept, 2 dropped
        do_reset();
        trace_if.trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            add_commit(39'h200 + 39'(4 * i), 32'h1000 + 32'(i), 1'b0);
            if (i < 8) push_exp(i, 39'h200 + 39'(4 * i), 32'h1000 + 32'(i), 1'b0, '0, '0);
        end
        run_burst();
        step();
        check("full_drop_cnt", 64'(drop_cnt_o), 64'd2);
        check("full_stalled_v", 64'(trace_if.trace_v), 64'd0);
        trace_if.trace_ready = 1'b1;
        wait_drain("drain_full");
        add_commit(39'h400, 32'h2000, 1'b0);
        push_exp(10, 39'h400, 32'h2000, 1'b0, '0, '0);
        run_burst();
        wait_drain("drain_after_full");
        check("full_drop_hold", 64'(drop_cnt_o), 64'd2);

        // Zero-PC filter: middle record popped but not emitted
        do_reset();
        add_commit(39'h100, 32'h3000, 1'b0);
        add_commit(39'h000, 32'h3001, 1'b0);
        add_commit(39'h104, 32'h3002, 1'b0);
        push_exp(0, 39'h100, 32'h3000, 1'b0, '0, '0);
        push_exp(2, 39'h104, 32'h3002, 1'b0, '0, '0);
        run_burst();
        wait_drain("drain_zero_pc");
        repeat (5) step();

        // Spurious writeback with empty FIFO, sticky
        do_reset();
        writeback(5'd3, 64'h33);
        check("err_spurious_set", 64'(err_spurious_wb_o), 64'd1);
        repeat (5) step();
        check("err_spurious_sticky", 64'(err_spurious_wb_o), 64'd1);
        check("err_ov_clear", 64'(err_wb_overflow_o), 64'd0);

        // Overflow: two writebacks while the head is blocked by back-pressure
        do_reset();
        check("reset_clears_sp", 64'(err_spurious_wb_o), 64'd0);
        trace_if.trace_ready = 1'b0;
        add_commit(39'h300, 32'h4000, 1'b1);
        push_exp(0, 39'h300, 32'h4000, 1'b1, 5'd1, 64'h11);
        run_burst();
        writeback(5'd1, 64'h11);
        writeback(5'd2, 64'h22);
        check("err_overflow_set", 64'(err_wb_overflow_o), 64'd1);
        check("ov_not_spurious", 64'(err_spurious_wb_o), 64'd0);
        trace_if.trace_ready = 1'b1;
        wait_drain("drain_overflow");

        // itag wrap with 4-bit tags: 17th commit carries itag 0
        do_reset();
        for (int i = 0; i < 17; i++) begin
            add_commit(39'h1000 + 39'(4 * i), 32'h5000 + 32'(i), 1'b0);
            push_exp(i % 16, 39'h1000 + 39'(4 * i), 32'h5000 + 32'(i), 1'b0, '0, '0);
        end
        run_burst();
        wait_drain("drain_wrap");

        // Reset mid-flight with pending entries
        trace_if.trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) add_commit(39'h500 + 39'(4 * i), 32'h6000, 1'b0);
        run_burst();
        trace_if.trace_ready = 1'b1;
        step();
        trace_if.trace_ready = 1'b0;
        check("pending_before_reset", 64'(trace_if.trace_v), 64'd1);
        reset_n_i = 1'b0;
        #1;
        check("async_reset_v", 64'(trace_if.trace_v), 64'd0);
        check("async_reset_itag", 64'(trace_if.trace_itag), 64'd0);
        repeat (3) step();
        reset_n_i = 1'b1;
        trace_if.trace_ready = 1'b1;
        repeat (15) step();
        add_commit(39'h600, 32'h7000, 1'b0);
        push_exp(0, 39'h600, 32'h7000, 1'b0, '0, '0);
        run_burst();
        wait_drain("drain_after_reset");
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
